// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud divider math used by
// both the emitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

  function automatic int calc_half(input int clk_freq_hz, input int baud_rate);
    return calc_div(clk_freq_hz, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Reset presets both flops high so an idle line is seen right after reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b1;
      synced <= 1'b1;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receiver with a one-entry holding buffer, valid/ready output
// handshake and sticky overrun / framing error flags.
module uart_receiver #(
  parameter int clk_freq_hz = 27_000_000,
  parameter int baud_rate   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  input  logic       i_clr_err,
  output logic       o_overrun,
  output logic       o_frame_err
);

  import uart_pkg::*;

  localparam int DIV  = calc_div(clk_freq_hz, baud_rate);
  localparam int HALF = calc_half(clk_freq_hz, baud_rate);
  localparam int CW   = $clog2(DIV);

  logic            rx_s;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;

  uart_rx_sync u_sync (
    .clk    (i_clk),
    .rst    (i_rst),
    .raw    (i_uart_rx),
    .synced (rx_s)
  );

  // Clears are written first so a set event later in the same cycle wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;
      if (i_clr_err) begin
        o_overrun   <= 1'b0;
        o_frame_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= CW'(HALF - 1);
          end
        end

        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
              cnt     <= CW'(DIV - 1);
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            cnt       <= CW'(DIV - 1);
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
              // A consumer read in this same cycle frees the buffer in time.
              if (!o_valid || i_ready) begin
                o_data  <= shift_reg;
                o_valid <= 1'b1;
              end else begin
                o_overrun <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        BREAK: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
